// File: rtl/fifo_read_stream.sv
// fifo_read_stream
//   Turns a FIFO pop interface with one cycle of read latency into a
//   valid/ready stream. Output comes from a 2-entry buffer. The buffer
//   always keeps a slot free for the word that is currently in flight, so
//   it never overflows and can sustain one word per cycle.
//
// Ports
//   Clk_Read    in   1           single clock of the block
//   Rst         in   1           asynchronous reset, active-low
//   Empty_Flag  in   1           FIFO empty indication
//   R_Data      in   Data_Width  FIFO read data, valid the cycle after R_En
//   R_En        out  1           FIFO pop request (combinational)
//   Out_Data    out  Data_Width  stream data (buffer head)
//   Out_Valid   out  1           stream data valid (registered state only)
//   Out_Ready   in   1           downstream accepts Out_Data
//   Xfer_Count  out  16          accepted-word counter, wraps at 0xFFFF
//                                (present only when RD_STREAM_CNT_EN is defined)
//
// Configuration macro: RD_STREAM_CNT_EN

module fifo_read_stream #(
    parameter int Data_Width = 8
) (
    input  logic                  Clk_Read,
    input  logic                  Rst,
    input  logic                  Empty_Flag,
    input  logic [Data_Width-1:0] R_Data,
    output logic                  R_En,
    output logic [Data_Width-1:0] Out_Data,
    output logic                  Out_Valid,
    input  logic                  Out_Ready
`ifdef RD_STREAM_CNT_EN
    ,
    output logic [15:0]           Xfer_Count
`endif
);

    logic [1:0]            count_q, count_d;
    logic                  head_q, head_d;
    logic                  tail_q, tail_d;
    logic                  in_flight_q;
    logic [Data_Width-1:0] mem_q [2];
    logic                  pop;
    logic [2:0]            level;

    assign Out_Valid = (count_q != 2'd0);
    assign Out_Data  = mem_q[head_q];

    always_comb begin
        pop   = Out_Valid & Out_Ready;
        // Occupancy after this edge, counting the word that is in flight.
        // pop implies count_q >= 1, so the subtraction cannot underflow.
        level = {1'b0, count_q} + {2'b00, in_flight_q} - {2'b00, pop};
        // Gating with Rst forces R_En low as soon as reset is asserted.
        R_En  = Rst & ~Empty_Flag & (level < 3'd2);
        count_d = level[1:0];
        head_d  = pop ? ~head_q : head_q;
        tail_d  = in_flight_q ? ~tail_q : tail_q;
    end

    always_ff @(posedge Clk_Read or negedge Rst) begin
        if (!Rst) begin
            count_q     <= '0;
            head_q      <= 1'b0;
            tail_q      <= 1'b0;
            in_flight_q <= 1'b0;
            mem_q[0]    <= '0;
            mem_q[1]    <= '0;
        end else begin
            count_q     <= count_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            in_flight_q <= R_En;
            if (in_flight_q) begin
                mem_q[tail_q] <= R_Data;
            end
        end
    end

`ifdef RD_STREAM_CNT_EN
    logic [15:0] xfer_cnt_q;

    always_ff @(posedge Clk_Read or negedge Rst) begin
        if (!Rst) begin
            xfer_cnt_q <= '0;
        end else if (pop) begin
            xfer_cnt_q <= xfer_cnt_q + 16'd1;
        end
    end

    assign Xfer_Count = xfer_cnt_q;
`endif

endmodule

// File: tb/tb_fifo_read_stream.sv
// tb_fifo_read_stream
//   Directed bench for fifo_read_stream. A small FIFO model supplies words
//   with one cycle of read latency. Inputs change on the falling edge, and
//   outputs are sampled 1 ns later, which is within the same clock cycle.

module tb_fifo_read_stream;

    logic       Clk_Read;
    logic       Rst;
    logic       Empty_Flag;
    logic [7:0] R_Data;
    logic       R_En;
    logic [7:0] Out_Data;
    logic       Out_Valid;
    logic       Out_Ready;
`ifdef RD_STREAM_CNT_EN
    logic [15:0] Xfer_Count;
`endif

    int checks = 0;
    int errors = 0;

    // FIFO model: words are appended by the stimulus and popped on R_En.
    logic [7:0] fifo_mem [64];
    int         wr_cnt = 0;
    int         rd_ptr = 0;

    assign Empty_Flag = (rd_ptr == wr_cnt);

    always @(posedge Clk_Read) begin
        if (R_En) begin
            R_Data <= fifo_mem[rd_ptr % 64];
            rd_ptr <= rd_ptr + 1;
        end
    end

    fifo_read_stream #(.Data_Width(8)) dut (
        .Clk_Read   (Clk_Read),
        .Rst        (Rst),
        .Empty_Flag (Empty_Flag),
        .R_Data     (R_Data),
        .R_En       (R_En),
        .Out_Data   (Out_Data),
        .Out_Valid  (Out_Valid),
        .Out_Ready  (Out_Ready)
`ifdef RD_STREAM_CNT_EN
        ,
        .Xfer_Count (Xfer_Count)
`endif
    );

    initial Clk_Read = 1'b0;
    always #5 Clk_Read = ~Clk_Read;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [7:0] w);
        fifo_mem[wr_cnt % 64] = w;
        wr_cnt = wr_cnt + 1;
    endtask

    // Advance one cycle, apply Out_Ready for it, then settle before sampling.
    task automatic cyc(input logic rdy);
        @(negedge Clk_Read);
        Out_Ready = rdy;
        #1;
    endtask

    task automatic release_rst(input logic rdy);
        @(negedge Clk_Read);
        Rst = 1'b1;
        Out_Ready = rdy;
        #1;
    endtask

    task automatic assert_rst;
        @(negedge Clk_Read);
        Rst = 1'b0;
        #1;
        check("rst_valid", {31'd0, Out_Valid}, 32'd0);
        check("rst_data",  {24'd0, Out_Data},  32'd0);
        check("rst_ren",   {31'd0, R_En},      32'd0);
    endtask

    task automatic chk_cycle(input string tag, input int c,
                             input logic ren, input logic vld, input logic [7:0] dat);
        check($sformatf("%s_ren_c%0d", tag, c), {31'd0, R_En}, {31'd0, ren});
        check($sformatf("%s_valid_c%0d", tag, c), {31'd0, Out_Valid}, {31'd0, vld});
        if (vld)
            check($sformatf("%s_data_c%0d", tag, c), {24'd0, Out_Data}, {24'd0, dat});
    endtask

    initial begin
        logic       ren_t [8];
        logic       vld_t [8];
        logic [7:0] dat_t [8];
        logic       rdy_t [8];

        Rst = 1'b0;
        Out_Ready = 1'b1;
        R_Data = 8'hEE;
        #1;
        check("por_valid", {31'd0, Out_Valid}, 32'd0);
        check("por_data",  {24'd0, Out_Data},  32'd0);
        check("por_ren",   {31'd0, R_En},      32'd0);

        // Three words, downstream always ready: 2-cycle latency.
        push(8'h11); push(8'h22); push(8'h33);
        repeat (2) @(negedge Clk_Read);
        #1;
        check("rst_hold_ren", {31'd0, R_En}, 32'd0);
        ren_t = '{1, 1, 1, 0, 0, 0, 0, 0};
        vld_t = '{0, 0, 1, 1, 1, 0, 0, 0};
        dat_t = '{8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h00, 8'h00, 8'h00};
        release_rst(1'b1);
        chk_cycle("basic", 0, ren_t[0], vld_t[0], dat_t[0]);
        for (int unsigned c = 1; c < 6; c++) begin
            cyc(1'b1);
            chk_cycle("basic", int'(c), ren_t[c], vld_t[c], dat_t[c]);
        end

        // Downstream stalled: two pops fill the buffer, then R_En stays low.
        assert_rst;
        push(8'h40); push(8'h41); push(8'h42); push(8'h43); push(8'h44);
        ren_t = '{1, 1, 0, 0, 0, 0, 0, 0};
        vld_t = '{0, 0, 1, 1, 1, 1, 0, 0};
        dat_t = '{8'h00, 8'h00, 8'h40, 8'h40, 8'h40, 8'h40, 8'h00, 8'h00};
        release_rst(1'b0);
        chk_cycle("stall", 0, ren_t[0], vld_t[0], dat_t[0]);
        for (int unsigned c = 1; c < 6; c++) begin
            cyc(1'b0);
            chk_cycle("stall", int'(c), ren_t[c], vld_t[c], dat_t[c]);
        end

        // Full buffer with Out_Ready toggling: refills track pops, order kept.
        push(8'h45); push(8'h46); push(8'h47);
        rdy_t = '{1, 0, 1, 0, 1, 1, 1, 1};
        ren_t = '{1, 0, 1, 0, 1, 1, 1, 1};
        vld_t = '{1, 1, 1, 1, 1, 1, 1, 1};
        dat_t = '{8'h40, 8'h41, 8'h41, 8'h42, 8'h42, 8'h43, 8'h44, 8'h45};
        for (int unsigned c = 0; c < 8; c++) begin
            cyc(rdy_t[c]);
            chk_cycle("toggle", int'(c), ren_t[c], vld_t[c], dat_t[c]);
        end

        // Reset with a buffered word (0x46) and one in flight (0x47):
        // both are discarded, and the next output is the next FIFO word.
        assert_rst;
        push(8'h5A); push(8'h5B);
        cyc(1'b1);
        check("rst_nonempty_ren", {31'd0, R_En}, 32'd0);
        ren_t = '{1, 1, 0, 0, 0, 0, 0, 0};
        vld_t = '{0, 0, 1, 1, 0, 0, 0, 0};
        dat_t = '{8'h00, 8'h00, 8'h5A, 8'h5B, 8'h00, 8'h00, 8'h00, 8'h00};
        release_rst(1'b1);
        chk_cycle("midrst", 0, ren_t[0], vld_t[0], dat_t[0]);
        for (int unsigned c = 1; c < 5; c++) begin
            cyc(1'b1);
            chk_cycle("midrst", int'(c), ren_t[c], vld_t[c], dat_t[c]);
        end

        // Long stream of 65537 words at one word per cycle.
        assert_rst;
`ifdef RD_STREAM_CNT_EN
        check("cnt_reset", {16'd0, Xfer_Count}, 32'd0);
`endif
        for (int unsigned i = 0; i < 64; i++) fifo_mem[i] = 8'(i);
        wr_cnt = rd_ptr + 65537;
        release_rst(1'b1);
        for (int unsigned c = 1; c <= 65538; c++) begin
            cyc(1'b1);
            if (c == 65536) check("stream_ren_last", {31'd0, R_En}, 32'd1);
            if (c == 65537) check("stream_ren_done", {31'd0, R_En}, 32'd0);
            if (c == 65538) check("stream_valid_last", {31'd0, Out_Valid}, 32'd1);
        end
        cyc(1'b1);
        check("stream_valid_end", {31'd0, Out_Valid}, 32'd0);
        check("stream_empty", {31'd0, Empty_Flag}, 32'd1);
`ifdef RD_STREAM_CNT_EN
        check("cnt_wrap", {16'd0, Xfer_Count}, 32'd1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
